// File: rtl/bram_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// bram_ctrl_pkg
// Shared definitions for the BRAM port sequencer/arbiter:
//   state_e     - sequencer state (INIT sweep, SERVE requesters)
//   REQ0 / REQ1 - requester indices used for grant/request vectors
// -----------------------------------------------------------------------------
package bram_ctrl_pkg;

   typedef enum logic {
      INIT  = 1'b0,
      SERVE = 1'b1
   } state_e;

   localparam int REQ0 = 0;
   localparam int REQ1 = 1;

endpackage

// File: rtl/bram_port_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter, one grant per cycle.
//   clka    in   clock
//   rstb    in   synchronous active-high reset (pointer -> requester 0)
//   req     in   [1:0] request vector, indexed by REQ0/REQ1
//   enable  in   when low no grant is issued and the pointer holds
//   gnt     out  [1:0] combinational one-hot (or zero) grant
//   ptr_q   out  registered priority pointer: index favoured on contention
// -----------------------------------------------------------------------------
module rr_arb2
   import bram_ctrl_pkg::*;
(
   input  logic       clka,
   input  logic       rstb,
   input  logic [1:0] req,
   input  logic       enable,
   output logic [1:0] gnt,
   output logic       ptr_q
);

   logic ptr_d;

   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      gnt   = 2'b00;
      ptr_d = ptr_q;
      if (enable) begin
         if (req[REQ0] && req[REQ1]) begin
            // The pointer value is itself the requester index to favour.
            gnt[ptr_q] = 1'b1;
         end else begin
            gnt = req;
         end
      end
      // After a grant, priority passes to the other requester.
      if (gnt[REQ0]) begin
         ptr_d = 1'(REQ1);
      end else if (gnt[REQ1]) begin
         ptr_d = 1'(REQ0);
      end
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // flop samples pre-edge values regardless of block ordering.
   always_ff @(posedge clka) begin
      if (rstb) begin
         ptr_q <= 1'b0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
// Sequencer and arbiter in front of one port of a resetable BRAM. After reset
// (or an init_req pulse) it writes INIT_VALUE to addresses 0..RST_DEPTH-1, one
// per cycle; the last of these writes releases the BRAM's reset-hold. Then it
// shares the port between two requesters with round-robin priority and
// returns read data with a per-requester valid strobe.
//   clka, rstb            clock; synchronous active-high reset
//   init_req              pulse: restart the sweep (honoured in SERVE only)
//   init_busy, init_done  sweep pending/in progress; pulse after last write
//   req/we/addr/din[01]   requester access interfaces
//   gnt0/gnt1             combinational grants (access taken this cycle)
//   rvalid0/1, rdata      read return, one cycle after a granted read
//   ram_we/addr/din/dout  BRAM port (dout has 1-cycle read latency)
// -----------------------------------------------------------------------------
module bram_port_arbiter
   import bram_ctrl_pkg::*;
#(
   parameter int                   RAM_WIDTH  = 16,
   parameter int                   WIDTH      = 9,
   parameter int                   RST_DEPTH  = 16,
   parameter logic [RAM_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                 clka,
   input  logic                 rstb,
   input  logic                 init_req,
   output logic                 init_busy,
   output logic                 init_done,
   input  logic                 req0,
   input  logic                 req1,
   input  logic                 we0,
   input  logic                 we1,
   input  logic [WIDTH-1:0]     addr0,
   input  logic [WIDTH-1:0]     addr1,
   input  logic [RAM_WIDTH-1:0] din0,
   input  logic [RAM_WIDTH-1:0] din1,
   output logic                 gnt0,
   output logic                 gnt1,
   output logic                 rvalid0,
   output logic                 rvalid1,
   output logic [RAM_WIDTH-1:0] rdata,
   output logic                 ram_we,
   output logic [WIDTH-1:0]     ram_addr,
   output logic [RAM_WIDTH-1:0] ram_din,
   input  logic [RAM_WIDTH-1:0] ram_dout
);

   localparam int CNT_W_RAW = $clog2(RST_DEPTH + 1);
   localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_DEPTH - 1);

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 rvalid0_q, rvalid0_d;
   logic                 rvalid1_q, rvalid1_d;
   logic                 init_done_q, init_done_d;
   logic [RAM_WIDTH-1:0] rdata_hold_q, rdata_hold_d;

   logic [1:0] req_vec;
   logic [1:0] gnt;
   logic       arb_en;
   // The top only needs the grants; the pointer is kept visible for debug.
   logic       unused_rr_ptr;

   assign req_vec[REQ0] = req0;
   assign req_vec[REQ1] = req1;

   // init_req pre-empts arbitration in the same cycle it is seen.
   assign arb_en = (state_q == SERVE) && !init_req && !rstb;

   rr_arb2 u_arb (
      .clka   (clka),
      .rstb   (rstb),
      .req    (req_vec),
      .enable (arb_en),
      .gnt    (gnt),
      .ptr_q  (unused_rr_ptr)
   );

   assign gnt0 = gnt[REQ0];
   assign gnt1 = gnt[REQ1];

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      init_done_d = 1'b0;
      ram_we      = 1'b0;
      ram_addr    = '0;
      ram_din     = '0;
      init_busy   = rstb || (state_q == INIT);

      case (state_q)
         INIT: begin
            ram_we   = !rstb;
            ram_addr = WIDTH'(cnt_q);
            ram_din  = INIT_VALUE;
            if (cnt_q == CNT_LAST) begin
               state_d     = SERVE;
               cnt_d       = '0;
               init_done_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         SERVE: begin
            if (init_req) begin
               state_d = INIT;
               cnt_d   = '0;
            end
            if (gnt[REQ0]) begin
               ram_we   = we0;
               ram_addr = addr0;
               ram_din  = din0;
            end else if (gnt[REQ1]) begin
               ram_we   = we1;
               ram_addr = addr1;
               ram_din  = din1;
            end
         end
         default: begin
            state_d = INIT;
            cnt_d   = '0;
         end
      endcase
   end

   assign rvalid0_d = gnt[REQ0] && !we0;
   assign rvalid1_d = gnt[REQ1] && !we1;

   // BRAM dout is valid exactly in the cycle after the read, so it is passed
   // straight through then and captured for holding in all other cycles.
   assign rdata_hold_d = (rvalid0_q || rvalid1_q) ? ram_dout : rdata_hold_q;

   always_ff @(posedge clka) begin
      if (rstb) begin
         state_q      <= INIT;
         cnt_q        <= '0;
         rvalid0_q    <= 1'b0;
         rvalid1_q    <= 1'b0;
         init_done_q  <= 1'b0;
         rdata_hold_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         rvalid0_q    <= rvalid0_d;
         rvalid1_q    <= rvalid1_d;
         init_done_q  <= init_done_d;
         rdata_hold_q <= rdata_hold_d;
      end
   end

   assign rvalid0   = rvalid0_q;
   assign rvalid1   = rvalid1_q;
   assign init_done = init_done_q;
   assign rdata     = rdata_hold_d;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_port_arbiter
// Directed bench for bram_port_arbiter with a behavioural BRAM. Stimulus pushes
// expected BRAM writes, read returns and init_done pulses (with the cycle in
// which each must appear) into queues; a monitor on the falling edge pops and
// compares whenever the DUT presents one of those events.
// -----------------------------------------------------------------------------
module tb_bram_port_arbiter;

   localparam int RAM_WIDTH = 16;
   localparam int WIDTH     = 9;
   localparam int RST_DEPTH = 16;

   logic                 clka;
   logic                 rstb;
   logic                 init_req;
   logic                 init_busy;
   logic                 init_done;
   logic                 req0, req1, we0, we1;
   logic [WIDTH-1:0]     addr0, addr1;
   logic [RAM_WIDTH-1:0] din0, din1;
   logic                 gnt0, gnt1, rvalid0, rvalid1;
   logic [RAM_WIDTH-1:0] rdata;
   logic                 ram_we;
   logic [WIDTH-1:0]     ram_addr;
   logic [RAM_WIDTH-1:0] ram_din;
   logic [RAM_WIDTH-1:0] ram_dout;

   bram_port_arbiter #(
      .RAM_WIDTH  (RAM_WIDTH),
      .WIDTH      (WIDTH),
      .RST_DEPTH  (RST_DEPTH),
      .INIT_VALUE (16'h0000)
   ) dut (
      .clka      (clka),
      .rstb      (rstb),
      .init_req  (init_req),
      .init_busy (init_busy),
      .init_done (init_done),
      .req0      (req0),
      .req1      (req1),
      .we0       (we0),
      .we1       (we1),
      .addr0     (addr0),
      .addr1     (addr1),
      .din0      (din0),
      .din1      (din1),
      .gnt0      (gnt0),
      .gnt1      (gnt1),
      .rvalid0   (rvalid0),
      .rvalid1   (rvalid1),
      .rdata     (rdata),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_din   (ram_din),
      .ram_dout  (ram_dout)
   );

   initial clka = 1'b0;
   always #5 clka = ~clka;

   // Behavioural single-port BRAM, read-first, one cycle read latency.
   logic [RAM_WIDTH-1:0] mem [0:(1<<WIDTH)-1];
   initial begin
      for (int i = 0; i < (1 << WIDTH); i++) mem[i] = 16'hDEAD;
      ram_dout = '0;
   end
   always @(posedge clka) begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
   end

   int cyc = 0;
   always @(posedge clka) cyc <= cyc + 1;

   typedef struct {
      logic [WIDTH-1:0]     addr;
      logic [RAM_WIDTH-1:0] data;
      int                   cyc;
   } exp_t;

   exp_t wr_q[$];
   exp_t rd0_q[$];
   exp_t rd1_q[$];
   int   done_q[$];

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      failures++;
      $display("FAIL %s: DUT event with nothing expected (cycle %0d)", name, cyc);
   endtask

   task automatic push_wr(input int a, input int d, input int c);
      exp_t e;
      e.addr = WIDTH'(a); e.data = RAM_WIDTH'(d); e.cyc = c;
      wr_q.push_back(e);
   endtask

   task automatic push_rd(input int port, input int d, input int c);
      exp_t e;
      e.addr = '0; e.data = RAM_WIDTH'(d); e.cyc = c;
      if (port == 0) rd0_q.push_back(e);
      else           rd1_q.push_back(e);
   endtask

   // Monitor: compares every DUT output event against the scoreboard.
   always @(negedge clka) begin
      exp_t e;
      if (ram_we === 1'b1) begin
         if (wr_q.size() == 0) unexpected("wr");
         else begin
            e = wr_q.pop_front();
            check("wr_addr", 32'(ram_addr), 32'(e.addr));
            check("wr_data", 32'(ram_din), 32'(e.data));
            check("wr_cycle", cyc, e.cyc);
         end
      end
      if (rvalid0 === 1'b1) begin
         if (rd0_q.size() == 0) unexpected("rvalid0");
         else begin
            e = rd0_q.pop_front();
            check("rd0_data", 32'(rdata), 32'(e.data));
            check("rd0_cycle", cyc, e.cyc);
         end
      end
      if (rvalid1 === 1'b1) begin
         if (rd1_q.size() == 0) unexpected("rvalid1");
         else begin
            e = rd1_q.pop_front();
            check("rd1_data", 32'(rdata), 32'(e.data));
            check("rd1_cycle", cyc, e.cyc);
         end
      end
      if (init_done === 1'b1) begin
         if (done_q.size() == 0) unexpected("init_done");
         else check("done_cycle", cyc, done_q.pop_front());
      end
   end

   task automatic step();
      @(posedge clka);
      #1;
   endtask

   task automatic neg();
      @(negedge clka);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int c0, t, s, u, v;

   initial begin
      rstb = 1'b1; init_req = 1'b0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 9'd3;   din0 = '0;
      req1 = 1'b0; we1 = 1'b0; addr1 = '0;     din1 = '0;

      // Reset: everything forced quiet, grants held off despite req0.
      repeat (3) begin
         neg();
         check("rst_ram_we", 32'(ram_we), 0);
         check("rst_gnt", 32'({gnt1, gnt0}), 0);
         check("rst_busy", 32'(init_busy), 1);
         check("rst_rvalid", 32'({rvalid1, rvalid0}), 0);
         check("rst_done", 32'(init_done), 0);
         step();
      end

      // Power-up sweep with req0 held; the read is served on SERVE entry.
      rstb = 1'b0;
      c0 = cyc;
      for (int i = 0; i < RST_DEPTH; i++) push_wr(i, 0, c0 + i);
      done_q.push_back(c0 + RST_DEPTH);
      push_rd(0, 0, c0 + RST_DEPTH + 1);
      for (int i = 0; i < RST_DEPTH; i++) begin
         neg();
         check("sweep_gnt0", 32'(gnt0), 0);
         check("sweep_busy", 32'(init_busy), 1);
         if (i == 0) check("release_done", 32'(init_done), 0);
         step();
      end
      neg();
      check("serve_busy", 32'(init_busy), 0);
      check("serve_gnt0", 32'(gnt0), 1);
      step();
      req0 = 1'b0;

      // Write 0xBEEF to addr 5, read it back on the next cycle.
      t = cyc;
      req0 = 1'b1; we0 = 1'b1; addr0 = 9'd5; din0 = 16'hBEEF;
      push_wr(5, 16'hBEEF, t);
      neg();
      check("wr5_gnt0", 32'(gnt0), 1);
      step();
      we0 = 1'b0;
      push_rd(0, 16'hBEEF, t + 2);
      neg();
      check("rd5_gnt0", 32'(gnt0), 1);
      check("rd5_ram_we", 32'(ram_we), 0);
      step();
      req0 = 1'b0;

      // Requester 1 alone for three writes; leaves priority with requester 0.
      for (int k = 0; k < 3; k++) begin
         req1 = 1'b1; we1 = 1'b1; addr1 = WIDTH'(10 + k); din1 = RAM_WIDTH'(16'h1111 * (k + 1));
         push_wr(10 + k, 16'h1111 * (k + 1), cyc);
         neg();
         check("solo_gnt", 32'({gnt1, gnt0}), 32'b10);
         step();
      end
      req1 = 1'b0; we1 = 1'b0;

      // Contention: both read for 4 cycles, grants alternate starting with 0.
      s = cyc;
      req0 = 1'b1; we0 = 1'b0; addr0 = 9'd5;
      req1 = 1'b1; we1 = 1'b0; addr1 = 9'd11;
      for (int k = 0; k < 4; k++) begin
         if (k % 2 == 0) push_rd(0, 16'hBEEF, s + k + 1);
         else            push_rd(1, 16'h2222, s + k + 1);
         neg();
         check("rr_gnt", 32'({gnt1, gnt0}), (k % 2 == 0) ? 32'b01 : 32'b10);
         step();
      end
      req0 = 1'b0; req1 = 1'b0;
      neg();
      step();
      neg();
      check("rdata_hold", 32'(rdata), 32'h2222);
      check("idle_rvalid", 32'({rvalid1, rvalid0}), 0);
      step();

      // A read granted just before init_req still returns its data.
      u = cyc;
      req0 = 1'b1; we0 = 1'b0; addr0 = 9'd12;
      push_rd(0, 16'h3333, u + 1);
      neg();
      check("pre_init_gnt0", 32'(gnt0), 1);
      step();
      u = cyc;
      req0 = 1'b0;
      init_req = 1'b1;
      req1 = 1'b1; we1 = 1'b0; addr1 = 9'd10;
      neg();
      check("init_req_gnt", 32'({gnt1, gnt0}), 0);
      check("init_req_we", 32'(ram_we), 0);
      step();
      init_req = 1'b0;
      for (int i = 0; i < RST_DEPTH; i++) push_wr(i, 0, u + 1 + i);
      done_q.push_back(u + 1 + RST_DEPTH);
      push_rd(1, 0, u + 2 + RST_DEPTH);
      for (int i = 0; i < RST_DEPTH; i++) begin
         init_req = (i == 5);  // ignored while sweeping
         neg();
         check("resweep_gnt1", 32'(gnt1), 0);
         check("resweep_busy", 32'(init_busy), 1);
         step();
      end
      init_req = 1'b0;
      neg();
      check("resweep_serve_gnt1", 32'(gnt1), 1);
      step();
      req1 = 1'b0;

      // Reset at cnt=7 mid-sweep: addr 7 never written, sweep restarts at 0.
      v = cyc;
      init_req = 1'b1;
      neg();
      step();
      init_req = 1'b0;
      for (int i = 0; i < 7; i++) push_wr(i, 0, v + 1 + i);
      repeat (7) begin
         neg();
         step();
      end
      rstb = 1'b1; init_req = 1'b1; req0 = 1'b1; we0 = 1'b1;
      repeat (2) begin
         neg();
         check("midrst_ram_we", 32'(ram_we), 0);
         check("midrst_busy", 32'(init_busy), 1);
         check("midrst_gnt", 32'({gnt1, gnt0}), 0);
         step();
      end
      rstb = 1'b0; init_req = 1'b0; req0 = 1'b0; we0 = 1'b0;
      for (int i = 0; i < RST_DEPTH; i++) push_wr(i, 0, v + 10 + i);
      done_q.push_back(v + 10 + RST_DEPTH);
      for (int i = 0; i < RST_DEPTH; i++) begin
         neg();
         check("restart_busy", 32'(init_busy), 1);
         if (i == 0) check("restart_done", 32'(init_done), 0);
         step();
      end
      neg();
      check("restart_serve_busy", 32'(init_busy), 0);
      step();
      repeat (3) step();

      check("wr_q_drained", wr_q.size(), 0);
      check("rd0_q_drained", rd0_q.size(), 0);
      check("rd1_q_drained", rd1_q.size(), 0);
      check("done_q_drained", done_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
